canright_inv_sbox_seq: RTL and testbench

//   Sequential AES inverse S-box: the decrypt-direction counterpart of the forward Canright S-box.

---
 rtl/canright_inv_sbox_seq.sv | 205 ++++++++++++++++++++
 tb/tb_canright_inv_sbox_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/canright_inv_sbox_seq.sv
// -----------------------------------------------------------------------------
// canright_inv_sbox_seq
//   Sequential AES inverse S-box behind a valid/ready byte stream.
//   The input byte goes through the inverse affine map, then gets inverted in
//   GF(2^8) as y^254 mod 0x11B:
//     - a load cycle,
//     - six square-and-multiply steps, each 8/DIGIT cycles on a digit-serial
//       multiplier (y -> y^3 -> y^7 -> ... -> y^127),
//     - one final squaring cycle (y^254).
//   Accept-to-out_valid latency is 6*(8/DIGIT)+2 cycles.
//   Optional macro CANRIGHT_INV_FWD_EN adds a 'fwd' input. With fwd=1 the
//   block computes the forward S-box instead: it skips the inverse affine map
//   and applies the forward affine map to the result.
// -----------------------------------------------------------------------------
module canright_inv_sbox_seq #(
   parameter int DIGIT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
`ifdef CANRIGHT_INV_FWD_EN
   input  logic       fwd,
`endif
   output logic       busy
);

   localparam int NDIG = 8 / DIGIT;
   localparam int DW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   generate
      if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8)) begin : g_bad_digit
         $error("canright_inv_sbox_seq: DIGIT must be 1, 2, 4 or 8");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, MUL, SQ, DONE} state_t;

   // ---------------------------------------------------------------------------
   // GF(2^8) helpers, reduction polynomial x^8+x^4+x^3+x+1
   // ---------------------------------------------------------------------------
   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
   endfunction

   // Squaring is linear: spread the bits to even positions, then reduce.
   function automatic logic [7:0] gf_sq(input logic [7:0] v);
      logic [14:0] t;
      t = '0;
      for (int i = 0; i < 8; i++) t[2*i] = v[i];
      for (int i = 14; i >= 8; i--) begin
         if (t[i]) t[i -: 9] = t[i -: 9] ^ 9'h11B;
      end
      return t[7:0];
   endfunction

   // One digit of a Horner multiply: p*x^DIGIT + a*d, digit bits MSB first.
   function automatic logic [7:0] mac_digit(input logic [7:0] p, input logic [7:0] a,
                                            input logic [DIGIT-1:0] d);
      logic [7:0] r;
      r = p;
      for (int i = DIGIT - 1; i >= 0; i--) r = xtime(r) ^ (d[i] ? a : 8'h00);
      return r;
   endfunction

   function automatic logic [7:0] inv_aff(input logic [7:0] x);
      return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
   endfunction

   function automatic logic [7:0] fwd_aff(input logic [7:0] v);
      return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t          state_q, state_d;
   logic [7:0]      din_q;    // raw byte captured on accept
   logic            loaded_q; // base/acc loaded from din_q for this byte
   logic [7:0]      base_q;
   logic [7:0]      acc_q;
   logic [7:0]      part_q;   // partial product of the current step
   logic [DW-1:0]   dcnt_q;   // digit index within a step
   logic [2:0]      step_q;   // square-and-multiply step, 0..5
   logic            fwd_sel;

   logic [7:0]       sq_acc;
   logic [DIGIT-1:0] b_digit;
   logic [7:0]       part_nxt;
   logic             last_digit;
   logic [7:0]       load_val;
   logic [7:0]       result;

   // Combinational datapath: squared accumulator, current digit, next partial product.
   always_comb begin
      sq_acc     = gf_sq(acc_q);
      b_digit    = base_q[DIGIT*(NDIG-1-int'(dcnt_q)) +: DIGIT];
      part_nxt   = mac_digit((dcnt_q == '0) ? 8'h00 : part_q, sq_acc, b_digit);
      last_digit = (dcnt_q == DW'(NDIG - 1));
      load_val   = fwd_sel ? din_q : inv_aff(din_q);
      result     = fwd_sel ? fwd_aff(sq_acc) : sq_acc;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and handshake outputs.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = MUL;
         end
         MUL: begin
            busy = 1'b1;
            if (loaded_q && step_q == 3'd5 && last_digit) state_d = SQ;
         end
         SQ: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers: capture, load, digit-serial multiply, final square.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every register here is a handful of flops, not a memory, so all get
      // reset; a mid-operation reset leaves no stale byte behind.
      if (!rst_n) begin
         din_q    <= 8'h00;
         loaded_q <= 1'b0;
         base_q   <= 8'h00;
         acc_q    <= 8'h00;
         part_q   <= 8'h00;
         dcnt_q   <= '0;
         step_q   <= 3'd0;
         out_data <= 8'h00;
      end else begin
         // NOTE: non-blocking assignments so every read sees the pre-edge value.
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  din_q    <= in_data;
                  loaded_q <= 1'b0;
                  dcnt_q   <= '0;
                  step_q   <= 3'd0;
               end
            end
            MUL: begin
               if (!loaded_q) begin
                  base_q   <= load_val;
                  acc_q    <= load_val;
                  loaded_q <= 1'b1;
               end else begin
                  part_q <= part_nxt;
                  if (last_digit) begin
                     dcnt_q <= '0;
                     acc_q  <= part_nxt;
                     step_q <= step_q + 3'd1;
                  end else begin
                     dcnt_q <= dcnt_q + DW'(1);
                  end
               end
            end
            SQ: begin
               acc_q    <= sq_acc;
               out_data <= result;
            end
            default: ;
         endcase
      end
   end

`ifdef CANRIGHT_INV_FWD_EN
   // Direction flag, sampled with the byte on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        fwd_sel <= 1'b0;
      else if (state_q == IDLE && in_valid) fwd_sel <= fwd;
   end
`else
   assign fwd_sel = 1'b0;
`endif

endmodule

// File: tb/tb_canright_inv_sbox_seq.sv
// -----------------------------------------------------------------------------
// tb_canright_inv_sbox_seq
//   Directed bench for canright_inv_sbox_seq with DIGIT=2 (latency 26).
//   The reference table comes from a brute-force GF(2^8) model: the forward
//   S-box is built from exhaustive inverse search, and then inverted.
// -----------------------------------------------------------------------------
module tb_canright_inv_sbox_seq;

   localparam int DIGIT = 2;
   localparam int LAT   = 6 * (8 / DIGIT) + 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       busy;
`ifdef CANRIGHT_INV_FWD_EN
   logic       fwd = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;
   logic [7:0] inv_tab [256];

   canright_inv_sbox_seq #(.DIGIT(DIGIT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef CANRIGHT_INV_FWD_EN
      .fwd       (fwd),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00; x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] m_inv(input logic [7:0] a);
      for (int z = 1; z < 256; z++) if (m_mul(a, 8'(z)) == 8'h01) return 8'(z);
      return 8'h00;
   endfunction

   function automatic logic [7:0] m_rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] m_sbox(input logic [7:0] x);
      logic [7:0] v;
      v = m_inv(x);
      return v ^ m_rotl(v, 1) ^ m_rotl(v, 2) ^ m_rotl(v, 3) ^ m_rotl(v, 4) ^ 8'h63;
   endfunction

   // ---------------- stimulus helpers ----------------
   // Accept one byte, wait for out_valid (bounded), check latency and data,
   // then let the out_ready=1 handshake return the block to IDLE.
   task automatic run_byte(input string tag, input logic [7:0] d, input logic [7:0] exp);
      int n;
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_lat"}, n, LAT);
      check({tag, "_data"}, out_data, exp);
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      for (int x = 0; x < 256; x++) inv_tab[m_sbox(8'(x))] = 8'(x);

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready, 1'b1);

      // Directed vectors
      run_byte("v63", 8'h63, 8'h00);
      run_byte("v7c", 8'h7C, 8'h01);
      run_byte("v00", 8'h00, 8'h52);
      run_byte("v16", 8'h16, 8'hFF);
      run_byte("vff", 8'hFF, 8'h7D);

      // Backpressure: result held, no re-accept while waiting
      out_ready = 1'b0;
      @(negedge clk);
      in_data = 8'hED; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      check("bp_lat", n, LAT);
      in_valid = 1'b1; in_data = 8'h00;
      for (int i = 0; i < 10; i++) begin
         check("bp_data", out_data, 8'h53);
         check("bp_valid", out_valid, 1'b1);
         check("bp_in_ready", in_ready, 1'b0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", out_valid, 1'b0);
      check("bp_release_ready", in_ready, 1'b1);

      // Input pulse while busy is ignored
      @(negedge clk);
      in_data = 8'h7C; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("bz_busy", busy, 1'b1);
      check("bz_in_ready", in_ready, 1'b0);
      @(negedge clk);
      in_data = 8'h00; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 4;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      check("bz_lat", n, LAT);
      check("bz_data", out_data, 8'h01);
      @(posedge clk); #1;

      // Reset in the middle of an operation
      @(negedge clk);
      in_data = 8'h16; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_busy", busy, 1'b0);
      check("mr_out_valid", out_valid, 1'b0);
      check("mr_out_data", out_data, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      run_byte("mr_v7c", 8'h7C, 8'h01);

`ifdef CANRIGHT_INV_FWD_EN
      fwd = 1'b1;
      run_byte("fwd00", 8'h00, 8'h63);
      run_byte("fwd53", 8'h53, 8'hED);
      fwd = 1'b0;
      run_byte("fwd_off", 8'hED, 8'h53);
`endif

      // Exhaustive sweep against the model table
      for (int i = 0; i < 256; i++) run_byte($sformatf("ex%02x", i), 8'(i), inv_tab[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
